// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader and its memory.
package imem_pkg;

  localparam int ADDR_W_DEF = 8;

  // Loader parser states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    S_BASE = 3'd1,
    S_CNT  = 3'd2,
    S_HI   = 3'd3,
    S_LO   = 3'd4,
    S_CSUM = 3'd5,
    DONE   = 3'd6,
    ERR    = 3'd7
  } state_t;

  // HALT opcode used as the default fill of unloaded memory words.
  localparam logic [4:0] HALT_OP = 5'b00001;

endpackage

// File: rtl/imem_loader.sv
// Byte-stream programmer for the instruction memory. Parses
// BASE, CNT, CNT x {HI, LO}, [CSUM] frames and emits one write per word.
// The CPU is held until a frame completes with a correct checksum.
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int CSUM_EN = 1
) (
  input  logic              mem_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_hold
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W:0]     r_cnt;
  logic [7:0]          r_csum;
  logic [7:0]          r_hi;
  logic                w_xfer;
  logic                w_start_ok;
  logic                w_last_word;

  assign w_xfer      = rx_valid && rx_ready;
  assign w_start_ok  = start && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERR));
  assign w_last_word = (r_cnt == (ADDR_W+1)'(1));

  assign busy     = rx_ready;
  assign done     = (r_state == DONE);
  assign err      = (r_state == ERR);
  assign cpu_hold = (r_state != DONE);

  // State register; reset aborts any frame in flight.
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode and Moore ready output.
  always_comb begin
    w_state_nxt = r_state;
    rx_ready    = 1'b0;
    case (r_state)
      IDLE, DONE, ERR: begin
        if (w_start_ok) w_state_nxt = S_BASE;
      end
      S_BASE: begin
        rx_ready = 1'b1;
        if (w_xfer) w_state_nxt = S_CNT;
      end
      S_CNT: begin
        rx_ready = 1'b1;
        if (w_xfer) w_state_nxt = S_HI;
      end
      S_HI: begin
        rx_ready = 1'b1;
        if (w_xfer) w_state_nxt = S_LO;
      end
      S_LO: begin
        rx_ready = 1'b1;
        if (w_xfer) begin
          if (!w_last_word)      w_state_nxt = S_HI;
          else if (CSUM_EN != 0) w_state_nxt = S_CSUM;
          else                   w_state_nxt = DONE;
        end
      end
      S_CSUM: begin
        rx_ready = 1'b1;
        if (w_xfer) w_state_nxt = (rx_data == r_csum) ? DONE : ERR;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Checksum accumulator, pointer/word counter and word assembly.
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_csum  <= '0;
      r_hi    <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= 1'b0;
      if (w_start_ok) r_csum <= '0;
      if (w_xfer && (r_state != S_CSUM)) r_csum <= r_csum ^ rx_data;
      if (w_xfer) begin
        case (r_state)
          S_BASE: r_ptr <= ADDR_W'(rx_data);
          S_CNT: begin
            // A zero count means a full memory image.
            if (rx_data == 8'd0) r_cnt <= {1'b1, {ADDR_W{1'b0}}};
            else                 r_cnt <= (ADDR_W+1)'(rx_data);
          end
          S_HI: r_hi <= rx_data;
          S_LO: begin
            wr_en   <= 1'b1;
            wr_addr <= r_ptr;
            wr_data <= {r_hi, rx_data};
            r_ptr   <= r_ptr + 1'b1;
            r_cnt   <= r_cnt - 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader (ADDR_W=8, CSUM_EN=1).
module tb_imem_loader;

  logic        mem_clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_hold;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  log_a[$];
  logic [15:0] log_d[$];

  imem_loader #(.ADDR_W(8), .CSUM_EN(1)) dut (
    .mem_clk (mem_clk),
    .rst_n   (rst_n),
    .start   (start),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .cpu_hold(cpu_hold)
  );

  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  // Record every write strobe, sampled mid-cycle.
  always @(negedge mem_clk) begin
    if (wr_en === 1'b1) begin
      log_a.push_back(wr_addr);
      log_d.push_back(wr_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present one byte after 'gap' idle cycles; returns 1 ns after its handshake edge.
  task automatic send(input logic [7:0] b, input int gap);
    int k;
    rx_valid = 1'b0;
    repeat (gap) tick();
    rx_valid = 1'b1;
    rx_data  = b;
    k = 0;
    while (rx_ready !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    if (k >= 20) chk("ready_timeout", 32'(rx_ready), 32'd1);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic clear_log();
    log_a.delete();
    log_d.delete();
  endtask

  logic [7:0] f1 [7] = '{8'h00, 8'h02, 8'h4C, 8'h04, 8'h11, 8'h00, 8'h5B};
  logic [7:0] f3 [7] = '{8'hFF, 8'h02, 8'h08, 8'h00, 8'h48, 8'h01, 8'hBC};

  initial begin
    logic [7:0] cs;
    logic [7:0] hb;
    int         seen [256];
    int         bad;

    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rst_n    = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_wr_en",    32'(wr_en),    32'd0);
    chk("rst_wr_addr",  32'(wr_addr),  32'd0);
    chk("rst_wr_data",  32'(wr_data),  32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_err",      32'(err),      32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    rst_n = 1'b1;
    tick();
    chk("idle_ready", 32'(rx_ready), 32'd0);

    // Frame 1: good frame, back-to-back
    clear_log();
    pulse_start();
    chk("f1_ready_after_start", 32'(rx_ready), 32'd1);
    chk("f1_busy_after_start",  32'(busy),     32'd1);
    for (int i = 0; i < 6; i++) send(f1[i], 0);
    chk("f1_hold_before_csum", 32'(cpu_hold), 32'd1);
    send(f1[6], 0);
    chk("f1_done",     32'(done),     32'd1);
    chk("f1_err",      32'(err),      32'd0);
    chk("f1_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("f1_busy",     32'(busy),     32'd0);
    tick();
    chk("f1_nwrites", 32'(log_a.size()), 32'd2);
    if (log_a.size() == 2) begin
      chk("f1_a0", 32'(log_a[0]), 32'h00);
      chk("f1_d0", 32'(log_d[0]), 32'h4C04);
      chk("f1_a1", 32'(log_a[1]), 32'h01);
      chk("f1_d1", 32'(log_d[1]), 32'h1100);
    end

    // Frame 2: same frame, bad checksum
    clear_log();
    pulse_start();
    chk("f2_done_cleared", 32'(done), 32'd0);
    for (int i = 0; i < 6; i++) send(f1[i], 0);
    send(8'h5A, 0);
    chk("f2_err",      32'(err),      32'd1);
    chk("f2_done",     32'(done),     32'd0);
    chk("f2_cpu_hold", 32'(cpu_hold), 32'd1);
    tick();
    chk("f2_nwrites", 32'(log_a.size()), 32'd2);
    if (log_a.size() == 2) begin
      chk("f2_d0", 32'(log_d[0]), 32'h4C04);
      chk("f2_d1", 32'(log_d[1]), 32'h1100);
    end

    // Frame 3: address wrap FF -> 00
    clear_log();
    pulse_start();
    chk("f3_err_cleared", 32'(err), 32'd0);
    for (int i = 0; i < 7; i++) send(f3[i], 0);
    chk("f3_done", 32'(done), 32'd1);
    tick();
    chk("f3_nwrites", 32'(log_a.size()), 32'd2);
    if (log_a.size() == 2) begin
      chk("f3_a0", 32'(log_a[0]), 32'hFF);
      chk("f3_d0", 32'(log_d[0]), 32'h0800);
      chk("f3_a1", 32'(log_a[1]), 32'h00);
      chk("f3_d1", 32'(log_d[1]), 32'h4801);
    end

    // Frame 4: CNT=0 loads 256 words starting at 0x10
    clear_log();
    pulse_start();
    cs = 8'h10 ^ 8'h00;
    send(8'h10, 0);
    send(8'h00, 0);
    for (int i = 0; i < 256; i++) begin
      hb = 8'(i) ^ 8'hA5;
      send(hb, 0);
      send(8'(i), 0);
      cs = cs ^ hb ^ 8'(i);
    end
    chk("f4_busy_before_csum", 32'(busy), 32'd1);
    send(cs, 0);
    chk("f4_done", 32'(done), 32'd1);
    tick();
    chk("f4_nwrites", 32'(log_a.size()), 32'd256);
    for (int i = 0; i < 256; i++) seen[i] = 0;
    bad = 0;
    for (int i = 0; i < log_a.size(); i++) begin
      seen[log_a[i]]++;
      if (i < 256) begin
        if (log_a[i] !== 8'(8'h10 + i)) bad++;
        if (log_d[i] !== {8'(i) ^ 8'hA5, 8'(i)}) bad++;
      end
    end
    chk("f4_seq_errors", 32'(bad), 32'd0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (seen[i] != 1) bad++;
    chk("f4_addr_coverage", 32'(bad), 32'd0);

    // Frame 5: frame 1 with random gaps and a stray start mid-frame
    clear_log();
    pulse_start();
    send(f1[0], $urandom_range(0, 3));
    send(f1[1], $urandom_range(0, 3));
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("f5_busy_after_stray_start", 32'(busy), 32'd1);
    for (int i = 2; i < 7; i++) send(f1[i], $urandom_range(0, 3));
    chk("f5_done",     32'(done),     32'd1);
    chk("f5_err",      32'(err),      32'd0);
    chk("f5_cpu_hold", 32'(cpu_hold), 32'd0);
    tick();
    chk("f5_nwrites", 32'(log_a.size()), 32'd2);
    if (log_a.size() == 2) begin
      chk("f5_a0", 32'(log_a[0]), 32'h00);
      chk("f5_d0", 32'(log_d[0]), 32'h4C04);
      chk("f5_a1", 32'(log_a[1]), 32'h01);
      chk("f5_d1", 32'(log_d[1]), 32'h1100);
    end

    // Frame 6: reset after HI byte of word 1, then a good frame
    clear_log();
    pulse_start();
    send(f1[0], 0);
    send(f1[1], 0);
    send(f1[2], 0);
    rst_n = 1'b0;
    #1;
    chk("f6_rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("f6_rst_wr_en",    32'(wr_en),    32'd0);
    chk("f6_rst_wr_addr",  32'(wr_addr),  32'd0);
    chk("f6_rst_wr_data",  32'(wr_data),  32'd0);
    chk("f6_rst_busy",     32'(busy),     32'd0);
    chk("f6_rst_done",     32'(done),     32'd0);
    chk("f6_rst_err",      32'(err),      32'd0);
    chk("f6_rst_cpu_hold", 32'(cpu_hold), 32'd1);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("f6_no_writes", 32'(log_a.size()), 32'd0);
    chk("f6_idle_ready", 32'(rx_ready), 32'd0);
    pulse_start();
    for (int i = 0; i < 7; i++) send(f1[i], 0);
    chk("f6_done",     32'(done),     32'd1);
    chk("f6_cpu_hold", 32'(cpu_hold), 32'd0);
    tick();
    chk("f6_nwrites", 32'(log_a.size()), 32'd2);
    if (log_a.size() == 2) begin
      chk("f6_a1", 32'(log_a[1]), 32'h01);
      chk("f6_d1", 32'(log_d[1]), 32'h1100);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
